// File: rtl/approx_adder_pkg.sv
// Shared helpers for the pipelined approximate adder.
// Holds the k clamp and the per-bit lower-part mask.
package approx_adder_pkg;

  // Approximation length is saturated at the operand width, never wrapped.
  function automatic int unsigned clamp_k(int unsigned k, int unsigned w);
    return (k > w) ? w : k;
  endfunction

  // Bit idx belongs to the OR-approximated lower part when idx < k.
  function automatic logic lo_mask(int unsigned k, int unsigned idx);
    return idx < k;
  endfunction

endpackage

// File: rtl/adder_seg.sv
// One carry-chain slice of the approximate adder.
// Ports: i_a/i_b slice operands, i_k clamped k, i_c carry-in,
//        o_s slice sum, o_c slice carry-out.
module adder_seg
  import approx_adder_pkg::*;
#(
  parameter int SW   = 3,
  parameter int BASE = 0,
  parameter int KW   = 3
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic [KW-1:0] i_k,
  input  logic          i_c,
  output logic [SW-1:0] o_s,
  output logic          o_c
);

  logic w_c;
  logic w_lo;

  // Lower-part bits emit a|b and a&b as carry; only the carry of the
  // top lower bit survives, because every lower bit ignores carry-in.
  always_comb begin
    w_c  = i_c;
    w_lo = 1'b0;
    o_s  = '0;
    for (int i = 0; i < SW; i++) begin
      w_lo = lo_mask(32'(i_k), unsigned'(BASE + i));
      if (w_lo) begin
        o_s[i] = i_a[i] | i_b[i];
        w_c    = i_a[i] & i_b[i];
      end else begin
        o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
        w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
      end
    end
    o_c = w_c;
  end

endmodule

// File: rtl/approx_adder_pipe.sv
// Pipelined lower-part-OR approximate adder, one slice per stage.
// Ports: clk, rst, in_valid/in_ready, a, b, approx_k,
//        out_valid/out_ready, sum (MSB is carry-out).
module approx_adder_pipe
  import approx_adder_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int SEGS  = 2,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    approx_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int SW = WIDTH / SEGS;

  if (WIDTH < 2 || WIDTH > 64 || SEGS < 1 ||
      (WIDTH % SEGS) != 0 || KW != $clog2(WIDTH + 1)) begin : g_bad
    $fatal(1, "approx_adder_pipe: illegal WIDTH/SEGS/KW");
  end

  logic [SEGS-1:0]  r_v;
  logic [WIDTH-1:0] r_a [SEGS];
  logic [WIDTH-1:0] r_b [SEGS];
  logic [KW-1:0]    r_k [SEGS];
  logic             r_c [SEGS];
  logic [WIDTH:0]   r_s [SEGS];

  logic [WIDTH-1:0] w_a  [SEGS];
  logic [WIDTH-1:0] w_b  [SEGS];
  logic [KW-1:0]    w_k  [SEGS];
  logic [WIDTH:0]   w_sn [SEGS];
  logic [SEGS-1:0]  w_ci;
  logic [SEGS-1:0]  w_co;
  logic [SEGS-1:0]  w_up;
  logic [SEGS-1:0]  w_rdy;
  logic [KW-1:0]    w_kc;
  logic             w_r;

  assign w_kc = KW'(clamp_k(32'(approx_k), unsigned'(WIDTH)));

  for (genvar s = 0; s < SEGS; s++) begin : g_st
    logic [SW-1:0]  w_ss;
    logic [WIDTH:0] w_sp;
    logic [WIDTH:0] w_mrg;

    if (s == 0) begin : g_first
      assign w_a[s]  = a;
      assign w_b[s]  = b;
      assign w_k[s]  = w_kc;
      assign w_ci[s] = 1'b0;
      assign w_up[s] = in_valid;
      assign w_sp    = '0;
    end else begin : g_next
      assign w_a[s]  = r_a[s-1];
      assign w_b[s]  = r_b[s-1];
      assign w_k[s]  = r_k[s-1];
      assign w_ci[s] = r_c[s-1];
      assign w_up[s] = r_v[s-1];
      assign w_sp    = r_s[s-1];
    end

    adder_seg #(
      .SW  (SW),
      .BASE(s * SW),
      .KW  (KW)
    ) u_seg (
      .i_a(w_a[s][s*SW +: SW]),
      .i_b(w_b[s][s*SW +: SW]),
      .i_k(w_k[s]),
      .i_c(w_ci[s]),
      .o_s(w_ss),
      .o_c(w_co[s])
    );

    always_comb begin
      w_mrg = w_sp;
      w_mrg[s*SW +: SW] = w_ss;
      if (s == SEGS - 1) w_mrg[WIDTH] = w_co[s];
    end

    assign w_sn[s] = w_mrg;
  end

  // A stage can take a beat when empty or when its content leaves;
  // the chain runs from the output back to the input.
  always_comb begin
    w_r   = out_ready;
    w_rdy = '0;
    for (int s = SEGS - 1; s >= 0; s--) begin
      w_r      = ~r_v[s] | w_r;
      w_rdy[s] = w_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int s = 0; s < SEGS; s++) begin
        r_a[s] <= '0;
        r_b[s] <= '0;
        r_k[s] <= '0;
        r_c[s] <= 1'b0;
        r_s[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SEGS; s++) begin
        if (w_rdy[s]) begin
          r_v[s] <= w_up[s];
          r_a[s] <= w_a[s];
          r_b[s] <= w_b[s];
          r_k[s] <= w_k[s];
          r_c[s] <= w_co[s];
          r_s[s] <= w_sn[s];
        end
      end
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = r_v[SEGS-1];
  assign sum       = r_s[SEGS-1];

endmodule
